seq_det_scheduler: RTL and testbench
====================================

# seq_det_scheduler

Round-robin scheduler that time-shares one "10101" Mealy pattern-detection engine across NCH independent serial bit streams. It saves and restores each channel's detector state, so every channel sees a private overlapping detector while only one bit is evaluated per cycle. It sits between the per-channel serial front ends and the event/statistics logic, reporting each detection with its channel number and keeping a saturating per-channel hit count.

## Interface
- NCH, default 4: number of serial channels (2..8).
- CNT_W, default 8: width of each per-channel hit counter.
- CH_W, default $clog2(NCH): width of the channel index.

- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  NCH  channel i offers bit in_bit[i].
- in_bit  input  NCH  serial data bit per channel.
- in_ready  output  NCH  one-hot grant, combinational; all-zero when no in_valid.
- clr_ch  input  NCH  synchronous per-channel clear of detector state and hit counter.
- det_valid  output  1  registered one-cycle pulse: a detection completed.
- det_ch  output  CH_W  channel of the detection; holds its last value otherwise.
- hit_cnt  output  NCH*CNT_W  per-channel saturating hit counters, channel i in bits [i*CNT_W +: CNT_W].

## Operation
- Transfer on channel i occurs when in_valid[i] and in_ready[i] are both high at a clock edge. At most one transfer occurs per cycle.
- Arbiter:
  - A pointer ptr selects the first in_valid channel at or after ptr, wrapping modulo NCH.
  - After a transfer on channel i, ptr becomes (i+1) mod NCH.
  - With no transfer, ptr holds.
  - in_ready does not depend on in_bit.
- Context: each channel has one 3-bit detector state. The engine reads the granted channel's context, computes the next state and detect flag combinationally, and writes the context back on the same edge.
- Detector states (encoding 000..100):
  - A: nothing matched. 1 -> B, 0 -> A.
  - B: "1". 1 -> B, 0 -> C.
  - C: "10". 1 -> D, 0 -> A.
  - D: "101". 1 -> B, 0 -> E.
  - E: "1010". 0 -> A; 1 -> D with detect. D is the overlap state, so "1010101" yields two detections.
  - Unused encodings go to A with no detect.
- On a detect:
  - det_valid is 1 and det_ch is the channel on the next cycle.
  - hit_cnt[ch] increments, saturating at 2^CNT_W-1.
- clr_ch[i]:
  - On the next edge, context[i] becomes A and hit_cnt[i] becomes 0.
  - If channel i transfers in the same cycle, the bit is consumed (in_ready behaves normally) but clear wins: context becomes A, no detect is reported, and no increment occurs.
  - Clears on other channels do not affect the transferring channel.
- Reset values: all contexts A, all hit_cnt 0, ptr 0, det_valid 0, det_ch 0. in_ready follows in_valid with ptr 0.

## Timing
- Latency: the transfer edge produces det_valid/det_ch/hit_cnt at that same edge, so they are visible the cycle after the completing bit is offered.
- Throughput: one bit per cycle in aggregate. With k channels continuously valid, each is granted once every k cycles.
- Single valid channel: it is granted every cycle, with no bubbles.
- det_valid is never high for two detections in one cycle.
- Asserting reset mid-stream clears everything immediately, with no clock required. The first transfer after reset deassertion sees context A.

## Test plan
- Single channel: ch0 sends 1,0,1,0,1 on 5 consecutive cycles, other channels idle.
  - Required: in_ready=0001 every cycle.
  - Required: det_valid=1, det_ch=0 the cycle after the 5th bit; hit_cnt[0]=1.
- Interleave: ch0 and ch1 both valid continuously; ch0 bits 1,0,1,0,1 and ch1 bits 0,0,0,0,0.
  - Required: grants alternate 0,1,0,1,…
  - Required: single detection on ch0 after the 9th transfer (ch0's 5th bit).
  - Required: hit_cnt[0]=1, hit_cnt[1]=0.
- Overlap and saturation: CNT_W=2, ch2 sends 1,0,1,0,1,0,1,0,1.
  - Required: detections after bits 5, 7 and 9.
  - Required: hit_cnt[2] reads 1, 2, then 3; a further "01" keeps it at 3.
- Clear collision:
  - Setup: ch3 sends 1,0,1,0.
  - Stimulus: on the final bit 1, clr_ch[3]=1.
  - Required: no det_valid and hit_cnt[3]=0.
  - Follow-up: ch3 then sends 0,1 -> no detect, because the context restarted at A.
- Context isolation: all 4 channels valid round-robin, each sending the 10101 prefix with different phase offsets.
  - Required: each channel detects exactly on its own 5th matching bit.
  - Required: det_ch matches that channel.
- Async reset:
  - Stimulus: reset asserted mid-cycle after ch0 has sent 1,0,1,0.
  - Required: outputs clear before the next edge.
  - Follow-up: after release, a single 1 produces no detect; ptr is 0.

Source files
------------

// File: rtl/seq_det_scheduler_if.sv
// seq_det_scheduler_if: per-channel serial inputs, grants, clears and detection/statistics outputs.
interface seq_det_scheduler_if #(
   parameter int NCH   = 4,
   parameter int CNT_W = 8,
   parameter int CH_W  = $clog2(NCH)
);
   logic [NCH-1:0]       in_valid;
   logic [NCH-1:0]       in_bit;
   logic [NCH-1:0]       in_ready;
   logic [NCH-1:0]       clr_ch;
   logic                 det_valid;
   logic [CH_W-1:0]      det_ch;
   logic [NCH*CNT_W-1:0] hit_cnt;
   modport master (output in_valid, in_bit, clr_ch, input in_ready, det_valid, det_ch, hit_cnt);
   modport slave  (input in_valid, in_bit, clr_ch, output in_ready, det_valid, det_ch, hit_cnt);
endinterface

// File: rtl/seq_det_scheduler.sv
// seq_det_scheduler: round-robin sharing of one overlapping "10101" Mealy detector across NCH streams,
// with per-channel saved detector context and saturating hit counters.
module seq_det_scheduler #(
   parameter int NCH   = 4,
   parameter int CNT_W = 8,
   parameter int CH_W  = $clog2(NCH)
) (
   input  logic                clk,
   input  logic                reset,
   seq_det_scheduler_if.slave  bus
);
   localparam logic [2:0] S_A = 3'd0;
   localparam logic [2:0] S_B = 3'd1;
   localparam logic [2:0] S_C = 3'd2;
   localparam logic [2:0] S_D = 3'd3;
   localparam logic [2:0] S_E = 3'd4;
   logic [CH_W-1:0]  r_ptr;
   logic [2:0]       r_ctx [NCH];
   logic [CNT_W-1:0] r_cnt [NCH];
   logic             r_det_valid;
   logic [CH_W-1:0]  r_det_ch;
   logic [NCH-1:0]   w_gnt;
   logic [CH_W-1:0]  w_gidx;
   logic [CH_W-1:0]  w_i;
   logic             w_found;
   logic [2:0]       w_cur;
   logic             w_bit;
   logic [2:0]       w_nxt;
   logic             w_hit;
   // first valid channel at or after r_ptr, wrapping modulo NCH
   always_comb begin
      w_gnt   = '0;
      w_gidx  = '0;
      w_i     = '0;
      w_found = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         w_i = CH_W'((int'(r_ptr) + k) % NCH);
         if (!w_found && bus.in_valid[w_i]) begin
            w_found     = 1'b1;
            w_gnt[w_i]  = 1'b1;
            w_gidx      = w_i;
         end
      end
   end
   assign w_cur = r_ctx[w_gidx];
   assign w_bit = bus.in_bit[w_gidx];
   always_comb begin
      w_nxt = (w_cur == S_A) ? (w_bit ? S_B : S_A) :
              (w_cur == S_B) ? (w_bit ? S_B : S_C) :
              (w_cur == S_C) ? (w_bit ? S_D : S_A) :
              (w_cur == S_D) ? (w_bit ? S_B : S_E) :
              (w_cur == S_E) ? (w_bit ? S_D : S_A) : S_A;
      w_hit = w_found && (w_cur == S_E) && w_bit && !bus.clr_ch[w_gidx];
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr       <= '0;
         r_det_valid <= 1'b0;
         r_det_ch    <= '0;
         for (int i = 0; i < NCH; i++) begin
            r_ctx[i] <= S_A;
            r_cnt[i] <= '0;
         end
      end else begin
         r_det_valid <= w_hit;
         if (w_hit) r_det_ch <= w_gidx;
         if (w_found) r_ptr <= (w_gidx == CH_W'(NCH - 1)) ? '0 : w_gidx + 1'b1;
         // a clear overrides the same-cycle transfer on that channel
         for (int i = 0; i < NCH; i++) begin
            if (bus.clr_ch[i]) begin
               r_ctx[i] <= S_A;
               r_cnt[i] <= '0;
            end else if (w_found && w_gidx == CH_W'(i)) begin
               r_ctx[i] <= w_nxt;
               if (w_hit && r_cnt[i] != '1) r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end
   assign bus.in_ready  = w_gnt;
   assign bus.det_valid = r_det_valid;
   assign bus.det_ch    = r_det_ch;
   always_comb begin
      bus.hit_cnt = '0;
      for (int i = 0; i < NCH; i++) bus.hit_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
   end
endmodule

// File: tb/tb_seq_det_scheduler.sv
// tb_seq_det_scheduler: directed test-plan sequences plus random traffic, checked against a
// history-based reference model (last five accepted bits per channel equal 1,0,1,0,1).
module tb_seq_det_scheduler;
   localparam int NCH   = 4;
   localparam int CNT_W = 2;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   seq_det_scheduler_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();
   seq_det_scheduler #(.NCH(NCH), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
   always #5 clk = ~clk;
   int m_ptr;
   int m_hist [NCH];
   int m_len [NCH];
   int m_cnt [NCH];
   logic m_dv;
   int m_dch;
   int last_g;
   logic [31:0] pat [NCH];
   int pos [NCH];
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic int mgrant(input logic [NCH-1:0] v);
      for (int k = 0; k < NCH; k++) if (v[(m_ptr + k) % NCH]) return (m_ptr + k) % NCH;
      return -1;
   endfunction
   task automatic model_reset();
      m_ptr = 0; m_dv = 1'b0; m_dch = 0;
      for (int i = 0; i < NCH; i++) begin m_hist[i] = 0; m_len[i] = 0; m_cnt[i] = 0; end
   endtask
   task automatic check_outs(input string tag);
      chk({tag, ".det_valid"}, 32'(bus.det_valid), 32'(m_dv));
      chk({tag, ".det_ch"}, 32'(bus.det_ch), 32'(m_dch));
      for (int i = 0; i < NCH; i++) chk($sformatf("%s.hit_cnt%0d", tag, i), 32'(bus.hit_cnt[i*CNT_W +: CNT_W]), 32'(m_cnt[i]));
   endtask
   // one clock: drive, check grant, clock, update model, check registered outputs
   task automatic step(input string tag, input logic [NCH-1:0] v, input logic [NCH-1:0] b, input logic [NCH-1:0] c);
      int g;
      logic hit;
      @(negedge clk);
      bus.in_valid = v; bus.in_bit = b; bus.clr_ch = c;
      #1;
      g = mgrant(v);
      chk({tag, ".in_ready"}, 32'(bus.in_ready), (g < 0) ? 32'd0 : (32'd1 << g));
      @(posedge clk);
      hit = 1'b0;
      if (g >= 0) begin
         m_ptr = (g + 1) % NCH;
         if (!c[g]) begin
            m_hist[g] = ((m_hist[g] << 1) | int'(b[g])) & 31;
            m_len[g]++;
            hit = (m_len[g] >= 5) && (m_hist[g] == 5'b10101);
            if (hit) begin
               m_dch = g;
               if (m_cnt[g] < (1 << CNT_W) - 1) m_cnt[g]++;
            end
         end
      end
      m_dv = hit;
      for (int i = 0; i < NCH; i++) if (c[i]) begin m_hist[i] = 0; m_len[i] = 0; m_cnt[i] = 0; end
      last_g = g;
      #1;
      check_outs(tag);
   endtask
   // plays pat[] (LSB first) on the channels in v; each channel advances only when granted
   task automatic play(input string tag, input logic [NCH-1:0] v, input int n);
      logic [NCH-1:0] b;
      for (int i = 0; i < NCH; i++) pos[i] = 0;
      for (int s = 0; s < n; s++) begin
         for (int i = 0; i < NCH; i++) b[i] = pat[i][pos[i]];
         step(tag, v, b, '0);
         if (last_g >= 0) pos[last_g]++;
      end
   endtask
   task automatic do_reset(input string tag);
      @(negedge clk);
      reset = 1'b1;
      bus.in_valid = '1;
      #1;
      model_reset();
      chk({tag, ".rst_ready"}, 32'(bus.in_ready), 32'd1);
      check_outs({tag, ".rst"});
      @(negedge clk);
      reset = 1'b0;
      bus.in_valid = '0;
   endtask
   initial begin
      bus.in_valid = '0; bus.in_bit = '0; bus.clr_ch = '0;
      model_reset();
      #2;
      check_outs("por");
      do_reset("init");
      for (int i = 0; i < NCH; i++) pat[i] = 32'b0;
      pat[0] = 32'b10101;
      play("single", 4'b0001, 5);
      pat[0] = 32'b10101; pat[1] = 32'b0;
      do_reset("r1");
      play("interleave", 4'b0011, 10);
      do_reset("r2");
      pat[2] = 32'b10_101010101;
      play("overlap_sat", 4'b0100, 11);
      do_reset("r3");
      step("clr", 4'b1000, 4'b1000, 4'b0000);
      step("clr", 4'b1000, 4'b0000, 4'b0000);
      step("clr", 4'b1000, 4'b1000, 4'b0000);
      step("clr", 4'b1000, 4'b0000, 4'b0000);
      step("clr_hit", 4'b1000, 4'b1000, 4'b1000);
      step("clr_after0", 4'b1000, 4'b0000, 4'b0000);
      step("clr_after1", 4'b1000, 4'b1000, 4'b0000);
      do_reset("r4");
      pat[0] = 32'b10101; pat[1] = 32'b10101_0; pat[2] = 32'b10101_00; pat[3] = 32'b10101_000;
      play("isolation", 4'b1111, 40);
      step("pre_async", 4'b0001, 4'b0001, 4'b0000);
      step("pre_async", 4'b0001, 4'b0000, 4'b0000);
      step("pre_async", 4'b0001, 4'b0001, 4'b0000);
      step("pre_async", 4'b0001, 4'b0000, 4'b0000);
      do_reset("async");
      step("post_async", 4'b0001, 4'b0001, 4'b0000);
      for (int s = 0; s < 400; s++)
         step("random", 4'($urandom), 4'($urandom),
              ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
